// File: rtl/dpcm_pkg.sv
// Shared defaults and helpers for the DPCM channel arbiter.
// Provides clog2 and the round-robin pick used by rr_arbiter.
package dpcm_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 4;
    localparam int MAX_N = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // First set bit of valid at or above ptr, wrapping at n.
    // Scanned from the far end so the nearest request is written last.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0] valid,
                                      input logic [2:0]       ptr,
                                      input int               n);
        pick_t p;
        int    j;
        p = '0;
        for (int k = MAX_N - 1; k >= 0; k--) begin
            if (k < n) begin
                j = (int'(ptr) + k) % n;
                if (valid[j]) begin
                    p.found = 1'b1;
                    p.idx   = 3'(j);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter over N requests.
// Ports: req/ptr/enable in; one-hot grant, grant index, found out.
module rr_arbiter
    import dpcm_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int PW = (N > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          found
);

    logic [MAX_N-1:0] w_req;
    logic [2:0]       w_ptr;
    pick_t            w_pick;

    assign w_req  = MAX_N'(req);
    assign w_ptr  = 3'(ptr);
    assign w_pick = rr_pick(w_req, w_ptr, N);

    assign found = w_pick.found;
    assign idx   = PW'(w_pick.idx);
    assign grant = (enable && w_pick.found) ? (N'(1) << w_pick.idx) : '0;

endmodule

// File: rtl/dpcm_channel_arbiter.sv
// Shares one DPCM difference encoder between N sample channels.
// Ports: clock/reset; in_valid/in_data/in_ready per channel;
// chan_clear per channel; out_valid/out_ready/out_data/out_chan/out_raw.
module dpcm_channel_arbiter
    import dpcm_pkg::*;
#(
    parameter  int N       = DEF_N,
    parameter  int W       = DEF_W,
    parameter  int REFRESH = 8,
    localparam int CW      = (N > 1) ? clog2(N) : 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    input  logic [N-1:0]   chan_clear,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [CW-1:0]  out_chan,
    output logic           out_raw
);

    localparam int CNTW = (REFRESH > 1) ? clog2(REFRESH) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(REFRESH - 1);

    logic [W-1:0]    r_prev [N];
    logic [CNTW-1:0] r_cnt  [N];
    logic [CW-1:0]   r_ptr;
    logic            r_out_valid;
    logic [W-1:0]    r_out_data;
    logic [CW-1:0]   r_out_chan;
    logic            r_out_raw;

    logic            w_can;
    logic            w_en;
    logic [N-1:0]    w_grant;
    logic [CW-1:0]   w_idx;
    logic            w_found;
    logic            w_xfer;
    logic [W-1:0]    w_sample;
    logic [W-1:0]    w_diff;
    logic            w_raw;
    logic [CW-1:0]   w_next_ptr;

    // Single output register: a slot frees up when it drains this cycle.
    assign w_can = !r_out_valid || out_ready;
    assign w_en  = w_can && !reset;

    rr_arbiter #(.N(N), .PW(CW)) u_arb (
        .req    (in_valid),
        .ptr    (r_ptr),
        .enable (w_en),
        .grant  (w_grant),
        .idx    (w_idx),
        .found  (w_found)
    );

    assign w_xfer     = w_en && w_found;
    assign w_sample   = in_data[w_idx*W +: W];
    assign w_diff     = w_sample - r_prev[w_idx];
    assign w_raw      = (r_cnt[w_idx] == '0);
    assign w_next_ptr = (int'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_raw   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_prev[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_chan  <= w_idx;
                r_out_data  <= w_raw ? w_sample : w_diff;
                r_out_raw   <= w_raw;
                r_ptr       <= w_next_ptr;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            // A clear in the same cycle as a transfer wins over its update.
            for (int i = 0; i < N; i++) begin
                if (chan_clear[i]) begin
                    r_prev[i] <= '0;
                    r_cnt[i]  <= '0;
                end else if (w_xfer && int'(w_idx) == i) begin
                    r_prev[i] <= w_sample;
                    r_cnt[i]  <= (r_cnt[i] == CNT_LAST) ? '0
                                                        : r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign in_ready  = w_grant;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_raw   = r_out_raw;

endmodule

// File: tb/tb_dpcm_channel_arbiter.sv
// Testbench for dpcm_channel_arbiter: directed scenarios plus random
// traffic, checked each cycle against a behavioural channel model.
module tb_dpcm_channel_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int RF = 8;
    localparam int MASK = (1 << W) - 1;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   chan_clear;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_chan;
    logic           out_raw;

    logic           b_reset;
    logic [N-1:0]   b_in_valid;
    logic [N*W-1:0] b_in_data;
    logic [N-1:0]   b_in_ready;
    logic           b_out_valid;
    logic [W-1:0]   b_out_data;
    logic [1:0]     b_out_chan;
    logic           b_out_raw;

    int n_vec = 0;
    int n_err = 0;

    int         m_prev [N];
    int         m_cnt  [N];
    int         m_ptr;
    logic       m_ov;
    logic [W-1:0] m_od;
    logic [1:0] m_oc;
    logic       m_or;

    always #5 clock = ~clock;

    dpcm_channel_arbiter #(.N(N), .W(W), .REFRESH(RF)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .chan_clear (chan_clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_raw    (out_raw)
    );

    dpcm_channel_arbiter #(.N(N), .W(W), .REFRESH(4)) dut4 (
        .clock      (clock),
        .reset      (b_reset),
        .in_valid   (b_in_valid),
        .in_data    (b_in_data),
        .in_ready   (b_in_ready),
        .chan_clear ('0),
        .out_valid  (b_out_valid),
        .out_ready  (1'b1),
        .out_data   (b_out_data),
        .out_chan   (b_out_chan),
        .out_raw    (b_out_raw)
    );

    task automatic idle();
        reset      = 1'b0;
        in_valid   = '0;
        in_data    = '0;
        chan_clear = '0;
        out_ready  = 1'b1;
    endtask

    task automatic set_data(input int ch, input int v);
        in_data[ch*W +: W] = W'(v);
    endtask

    // One clock: check grant before the edge, outputs after it.
    task automatic step();
        int       g;
        bit       found;
        bit       can;
        int       d;
        logic [N-1:0] er;
        #1;
        can   = !m_ov || out_ready;
        found = 0;
        g     = 0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (!found && in_valid[j]) begin
                found = 1;
                g     = j;
            end
        end
        er = (can && found && !reset) ? (N'(1) << g) : '0;
        d  = int'(in_data[g*W +: W]);
        n_vec++;
        if (in_ready !== er) begin
            n_err++;
            $display("FAIL in_ready: got %b want %b", in_ready, er);
        end
        @(posedge clock);
        #1;
        if (reset) begin
            m_ptr = 0; m_ov = 0; m_od = '0; m_oc = '0; m_or = 0;
            for (int i = 0; i < N; i++) begin
                m_prev[i] = 0;
                m_cnt[i]  = 0;
            end
        end else begin
            if (er != '0) begin
                m_ov = 1;
                m_oc = 2'(g);
                m_or = (m_cnt[g] == 0);
                m_od = m_or ? W'(d) : W'((d - m_prev[g]) & MASK);
                m_prev[g] = d;
                m_cnt[g]  = (m_cnt[g] + 1) % RF;
                m_ptr = (g + 1) % N;
            end else if (out_ready) begin
                m_ov = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (chan_clear[i]) begin
                    m_prev[i] = 0;
                    m_cnt[i]  = 0;
                end
            end
        end
        n_vec++;
        if (out_valid !== m_ov) begin
            n_err++;
            $display("FAIL out_valid: got %b want %b", out_valid, m_ov);
        end
        n_vec++;
        if (out_data !== m_od || out_chan !== m_oc || out_raw !== m_or) begin
            n_err++;
            $display("FAIL out_word: got d=%0d c=%0d r=%b want d=%0d c=%0d r=%b",
                     out_data, out_chan, out_raw, m_od, m_oc, m_or);
        end
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset    = 1'b1;
        in_valid = '1;
        step();
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_chan !== '0
            || out_raw !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b d=%0d c=%0d r=%b want 0",
                     out_valid, out_data, out_chan, out_raw);
        end
        n_vec++;
        if (in_ready !== '0) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 0000", in_ready);
        end
        idle();
    endtask

    task automatic test_single_channel();
        int smp [4] = '{3, 5, 2, 2};
        int exd [4] = '{3, 2, 13, 0};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            in_valid = 4'b0001;
            set_data(0, smp[k]);
            step();
            n_vec++;
            if (out_valid !== 1'b1 || out_chan !== 2'd0
                || out_data !== W'(exd[k]) || out_raw !== (k == 0)) begin
                n_err++;
                $display("FAIL single_%0d: got v=%b c=%0d d=%0d r=%b want d=%0d",
                         k, out_valid, out_chan, out_data, out_raw, exd[k]);
            end
        end
        idle();
    endtask

    task automatic test_round_robin();
        do_reset();
        in_valid = '1;
        for (int i = 0; i < N; i++) set_data(i, i + 1);
        for (int k = 0; k < 8; k++) begin
            step();
            n_vec++;
            if (out_chan !== 2'(k % N)
                || out_data !== ((k < N) ? W'(k + 1) : W'(0))
                || out_raw !== (k < N)) begin
                n_err++;
                $display("FAIL rr_%0d: got c=%0d d=%0d r=%b", k, out_chan,
                         out_data, out_raw);
            end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 4'b0001;
        set_data(0, 5);
        step();
        in_valid  = 4'b0010;
        set_data(1, 9);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 4'd5 || out_chan !== 2'd0
                || in_ready !== '0) begin
                n_err++;
                $display("FAIL hold_%0d: got v=%b d=%0d c=%0d rdy=%b",
                         k, out_valid, out_data, out_chan, in_ready);
            end
        end
        out_ready = 1'b1;
        step();
        n_vec++;
        if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_data !== 4'd9
            || out_raw !== 1'b1) begin
            n_err++;
            $display("FAIL drain: got v=%b c=%0d d=%0d r=%b want 1 1 9 1",
                     out_valid, out_chan, out_data, out_raw);
        end
        idle();
        step();
    endtask

    task automatic test_refresh4();
        int prev;
        int d;
        b_in_valid = '0;
        b_in_data  = '0;
        b_reset    = 1'b1;
        @(posedge clock);
        #1;
        b_reset = 1'b0;
        prev = 0;
        for (int s = 0; s < 9; s++) begin
            d = $urandom_range(0, MASK);
            b_in_valid = 4'b0010;
            b_in_data  = '0;
            b_in_data[W +: W] = W'(d);
            @(posedge clock);
            #1;
            n_vec++;
            if (b_out_valid !== 1'b1 || b_out_chan !== 2'd1
                || b_out_raw !== (s % 4 == 0)
                || b_out_data !== ((s % 4 == 0) ? W'(d)
                                                : W'((d - prev) & MASK))) begin
                n_err++;
                $display("FAIL refresh4_%0d: got v=%b c=%0d r=%b d=%0d",
                         s, b_out_valid, b_out_chan, b_out_raw, b_out_data);
            end
            prev = d;
        end
        b_in_valid = '0;
        b_reset    = 1'b1;
    endtask

    task automatic test_clear();
        do_reset();
        in_valid = 4'b0100;
        set_data(2, 4);
        step();
        set_data(2, 7);
        chan_clear = 4'b0100;
        step();
        n_vec++;
        if (out_data !== 4'd3 || out_raw !== 1'b0 || out_chan !== 2'd2) begin
            n_err++;
            $display("FAIL clear_same: got d=%0d r=%b want 3 0", out_data,
                     out_raw);
        end
        chan_clear = '0;
        set_data(2, 9);
        step();
        n_vec++;
        if (out_data !== 4'd9 || out_raw !== 1'b1) begin
            n_err++;
            $display("FAIL clear_next: got d=%0d r=%b want 9 1", out_data,
                     out_raw);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        set_data(0, 2);
        step();
        set_data(0, 11);
        step();
        reset = 1'b1;
        step();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got out_valid=%b want 0", out_valid);
        end
        reset     = 1'b0;
        out_ready = 1'b1;
        set_data(0, 6);
        step();
        n_vec++;
        if (out_data !== 4'd6 || out_raw !== 1'b1 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_after: got d=%0d r=%b want 6 1", out_data,
                     out_raw);
        end
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid   = N'($urandom);
            in_data    = (N*W)'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            chan_clear = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            reset      = ($urandom_range(0, 99) == 0);
            step();
        end
        idle();
    endtask

    initial begin
        b_reset    = 1'b1;
        b_in_valid = '0;
        b_in_data  = '0;
        idle();
        m_ptr = 0; m_ov = 0; m_od = '0; m_oc = '0; m_or = 0;
        for (int i = 0; i < N; i++) begin
            m_prev[i] = 0;
            m_cnt[i]  = 0;
        end
        @(posedge clock);
        #1;
        test_reset();
        test_single_channel();
        test_round_robin();
        test_back_to_back();
        test_refresh4();
        test_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
